// File: rtl/rx_data_to_clk_point_checker_if.sv
// Received mainband beat bus for the Data-to-CLK point checker.
// One bit per lane per valid beat.
interface rx_data_to_clk_point_checker_if;
  logic        i_rx_data_valid;
  logic [15:0] i_rx_lane_data;

  modport master (
    output i_rx_data_valid,
    output i_rx_lane_data
  );

  modport slave (
    input i_rx_data_valid,
    input i_rx_lane_data
  );
endinterface

// File: rtl/rx_data_to_clk_point_checker.sv
// Receiver side of the Data-to-CLK point test: PRBS23 regen,
// per-lane mismatch counting and pass/fail vector.
module rx_data_to_clk_point_checker #(
  parameter int          NUM_SAMPLES   = 128,
  parameter int unsigned ERR_THRESHOLD = 0,
  parameter int          CNT_W         = 8,
  parameter logic [22:0] SEED          = 23'h1DBFBC
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [15:0] i_lane_mask,
  rx_data_to_clk_point_checker_if.slave rx,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_result,
  output logic        o_err_any
);

  localparam int SCW = $clog2(NUM_SAMPLES + 1);
  localparam logic [SCW-1:0] LAST = SCW'(NUM_SAMPLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    DONE
  } state_t;

  state_t           state;
  logic [22:0]      lfsr;
  logic [SCW-1:0]   cnt;
  logic [15:0]      mask;
  logic [CNT_W-1:0] err [16];
  logic [15:0]      pass;
  logic [22:0]      lfsr_nxt;

  // LFSR advance and per-lane pass evaluation
  always_comb begin
    lfsr_nxt = {lfsr[21:0],
                lfsr[22] ^ lfsr[20] ^ lfsr[17] ^
                lfsr[14] ^ lfsr[6] ^ lfsr[1]};
    pass = '0;
    for (int i = 0; i < 16; i++) begin
      pass[i] = mask[i] &&
                (32'(err[i]) <= ERR_THRESHOLD);
    end
  end

  // Test FSM with registered outputs
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lfsr      <= SEED;
      cnt       <= '0;
      mask      <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_result  <= '0;
      o_err_any <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        err[i] <= '0;
      end
    end else begin
      o_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_start) begin
            lfsr   <= SEED;
            cnt    <= '0;
            mask   <= i_lane_mask;
            o_busy <= 1'b1;
            state  <= COMPARE;
            for (int i = 0; i < 16; i++) begin
              err[i] <= '0;
            end
          end
        end
        COMPARE: begin
          if (i_abort) begin
            o_busy <= 1'b0;
            state  <= IDLE;
          end else if (rx.i_rx_data_valid) begin
            for (int i = 0; i < 16; i++) begin
              if (mask[i] &&
                  (rx.i_rx_lane_data[i] != lfsr[i]) &&
                  (err[i] != CNT_MAX)) begin
                err[i] <= err[i] + 1'b1;
              end
            end
            lfsr <= lfsr_nxt;
            cnt  <= cnt + 1'b1;
            if (cnt == LAST) begin
              o_busy <= 1'b0;
              state  <= DONE;
            end
          end
        end
        DONE: begin
          o_result  <= pass;
          o_err_any <= |(mask & ~pass);
          o_done    <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_data_to_clk_point_checker.sv
// Bench for rx_data_to_clk_point_checker: two instances
// (threshold 4 / 8-bit counters, threshold 2 / 2-bit counters).
module tb_rx_data_to_clk_point_checker;
  localparam int NS = 128;
  localparam logic [22:0] SEED = 23'h1DBFBC;

  logic CLK = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0;
  logic abort0 = 1'b0, abort1 = 1'b0;
  logic [15:0] mask = '0;
  logic busy0, done0, any0, busy1, done1, any1;
  logic [15:0] res0, res1;

  always #5 CLK = ~CLK;

  rx_data_to_clk_point_checker_if bus ();

  rx_data_to_clk_point_checker #(
    .NUM_SAMPLES(NS), .ERR_THRESHOLD(4), .CNT_W(8), .SEED(SEED)
  ) u0 (
    .CLK(CLK), .rst_n(rst_n), .i_start(start0), .i_abort(abort0),
    .i_lane_mask(mask), .rx(bus.slave), .o_busy(busy0),
    .o_done(done0), .o_result(res0), .o_err_any(any0)
  );

  rx_data_to_clk_point_checker #(
    .NUM_SAMPLES(NS), .ERR_THRESHOLD(2), .CNT_W(2), .SEED(SEED)
  ) u1 (
    .CLK(CLK), .rst_n(rst_n), .i_start(start1), .i_abort(abort1),
    .i_lane_mask(mask), .rx(bus.slave), .o_busy(busy1),
    .o_done(done1), .o_result(res1), .o_err_any(any1)
  );

  typedef struct {
    int          cyc;
    logic        busy;
    logic [15:0] res;
    logic        any;
  } obs_t;

  obs_t        obs0 [$];
  obs_t        obs1 [$];
  logic [16:0] exp0 [$];
  logic [16:0] exp1 [$];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int          t0 = 0;
  logic [22:0] lf;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    obs_t o;
    if (done0) begin
      o.cyc = cyc; o.busy = busy0; o.res = res0; o.any = any0;
      obs0.push_back(o);
    end
    if (done1) begin
      o.cyc = cyc; o.busy = busy1; o.res = res1; o.any = any1;
      obs1.push_back(o);
    end
  end

  function automatic logic [22:0] adv(input logic [22:0] l);
    return {l[21:0], l[22] ^ l[20] ^ l[17] ^ l[14] ^ l[6] ^ l[1]};
  endfunction

  task automatic do_start(input int which, input logic [15:0] m);
    @(negedge CLK);
    mask = m;
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    t0 = cyc;
    lf = SEED;
    @(negedge CLK);
    start0 = 1'b0;
    start1 = 1'b0;
    mask = ~m;
  endtask

  task automatic drive(input int which, input logic [15:0] m,
                       input int n, input bit gap,
                       input logic [15:0] every,
                       input logic [15:0] fa, input int ka,
                       input logic [15:0] fb, input int kb,
                       input bit abort_last);
    int cnt [16];
    int thr, mx;
    logic [15:0] p, fl;
    thr = (which == 0) ? 4 : 2;
    mx  = (which == 0) ? 255 : 3;
    p = '0;
    for (int l = 0; l < 16; l++) begin
      cnt[l] = 0;
      for (int b = 0; b < n; b++)
        if (every[l] || (fa[l] && b < ka) || (fb[l] && b < kb))
          cnt[l]++;
      if (cnt[l] > mx) cnt[l] = mx;
      p[l] = m[l] && (cnt[l] <= thr);
    end
    if (!abort_last && n == NS) begin
      if (which == 0) exp0.push_back({p, |(m & ~p)});
      else exp1.push_back({p, |(m & ~p)});
    end
    for (int b = 0; b < n; b++) begin
      if (gap && b > 0) begin
        bus.i_rx_data_valid = 1'b0;
        bus.i_rx_lane_data = ~lf[15:0];
        @(negedge CLK);
      end
      fl = every | ((b < ka) ? fa : 16'h0) | ((b < kb) ? fb : 16'h0);
      bus.i_rx_data_valid = 1'b1;
      bus.i_rx_lane_data = lf[15:0] ^ fl;
      if (abort_last && b == n - 1) begin
        if (which == 0) abort0 = 1'b1; else abort1 = 1'b1;
      end
      @(negedge CLK);
      lf = adv(lf);
    end
    bus.i_rx_data_valid = 1'b0;
    bus.i_rx_lane_data = '0;
    abort0 = 1'b0;
    abort1 = 1'b0;
  endtask

  task automatic get_done(input int which, input int budget,
                          output obs_t o, output logic [16:0] e,
                          output bit ok);
    for (int k = 0; k < budget; k++) begin
      if ((which == 0 ? obs0.size() : obs1.size()) > 0) break;
      @(negedge CLK);
    end
    ok = (which == 0 ? obs0.size() : obs1.size()) > 0;
    o = '{0, 1'b0, 16'h0, 1'b0};
    e = '0;
    if (ok) begin
      if (which == 0) begin o = obs0.pop_front(); e = exp0.pop_front(); end
      else begin o = obs1.pop_front(); e = exp1.pop_front(); end
    end
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if ({busy0, done0, res0, any0} !== 18'h0) begin
      fails++;
      $display("FAIL reset_u0: got %b/%b/%h/%b want 0/0/0000/0",
               busy0, done0, res0, any0);
    end
    tests++;
    if ({busy1, done1, res1, any1} !== 18'h0) begin
      fails++;
      $display("FAIL reset_u1: got %b/%b/%h/%b want 0/0/0000/0",
               busy1, done1, res1, any1);
    end
    repeat (3) @(negedge CLK);
    rst_n = 1'b1;
  endtask

  task automatic test_clean(input string nm, input bit gap,
                            input int lat);
    obs_t o; logic [16:0] e; bit ok;
    do_start(0, 16'hFFFF);
    tests++;
    if (busy0 !== 1'b1) begin
      fails++;
      $display("FAIL %s_busy: got %b want 1", nm, busy0);
    end
    drive(0, 16'hFFFF, NS, gap, 16'h0, 16'h0, 0, 16'h0, 0, 1'b0);
    get_done(0, 10, o, e, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s_timeout: no o_done", nm);
    end else begin
      tests++;
      if (o.cyc - t0 !== lat) begin
        fails++;
        $display("FAIL %s_latency: got %0d want %0d", nm, o.cyc - t0, lat);
      end
      tests++;
      if ({o.res, o.any, o.busy} !== {16'hFFFF, 1'b0, 1'b0} ||
          e !== {16'hFFFF, 1'b0}) begin
        fails++;
        $display("FAIL %s_result: got %h/%b busy %b want ffff/0 busy 0",
                 nm, o.res, o.any, o.busy);
      end
    end
    repeat (3) @(negedge CLK);
    tests++;
    if (obs0.size() !== 0) begin
      fails++;
      $display("FAIL %s_pulse: extra done cycles %0d want 0", nm, obs0.size());
      obs0.delete();
    end
  endtask

  task automatic test_run(input string nm, input int which,
                          input logic [15:0] m, input logic [15:0] every,
                          input logic [15:0] fa, input int ka,
                          input logic [15:0] fb, input int kb,
                          input logic [16:0] want);
    obs_t o; logic [16:0] e; bit ok;
    do_start(which, m);
    drive(which, m, NS, 1'b0, every, fa, ka, fb, kb, 1'b0);
    get_done(which, 10, o, e, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s_timeout: no o_done", nm);
    end else begin
      tests++;
      if ({o.res, o.any} !== want || e !== want) begin
        fails++;
        $display("FAIL %s: got %h/%b want %h/%b (model %h)",
                 nm, o.res, o.any, want[16:1], want[0], e[16:1]);
      end
    end
  endtask

  task automatic test_abort(input string nm, input int n);
    do_start(0, 16'hFFFF);
    drive(0, 16'hFFFF, n, 1'b0, 16'h0, 16'h0, 0, 16'h0, 0, 1'b1);
    repeat (6) @(negedge CLK);
    tests++;
    if (obs0.size() !== 0 || busy0 !== 1'b0) begin
      fails++;
      $display("FAIL %s_nodone: dones %0d busy %b want 0 0",
               nm, obs0.size(), busy0);
      obs0.delete();
    end
    tests++;
    if ({res0, any0} !== {16'hFFF7, 1'b1}) begin
      fails++;
      $display("FAIL %s_hold: got %h/%b want fff7/1", nm, res0, any0);
    end
  endtask

  task automatic test_reset_mid();
    do_start(0, 16'hFFFF);
    drive(0, 16'hFFFF, 60, 1'b0, 16'h0, 16'h0, 0, 16'h0, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy0, done0, res0, any0} !== 18'h0) begin
      fails++;
      $display("FAIL midreset: got %b/%b/%h/%b want 0/0/0000/0",
               busy0, done0, res0, any0);
    end
    repeat (2) @(negedge CLK);
    rst_n = 1'b1;
    repeat (80) @(negedge CLK);
    tests++;
    if (obs0.size() !== 0) begin
      fails++;
      $display("FAIL midreset_nodone: dones %0d want 0", obs0.size());
      obs0.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_rx_data_valid = 1'b0;
    bus.i_rx_lane_data = '0;
    test_reset();
    test_clean("clean", 1'b0, NS + 2);
    test_clean("gaps", 1'b1, 2 * NS + 1);
    test_run("mask_all", 0, 16'h00FF, 16'hFFFF, 16'h0, 0,
             16'h0, 0, {16'h0000, 1'b1});
    test_run("mask_hi", 0, 16'h00FF, 16'hFF00, 16'h0, 0,
             16'h0, 0, {16'h00FF, 1'b0});
    test_run("threshold", 0, 16'hFFFF, 16'h0, 16'h0008, 5,
             16'h0200, 4, {16'hFFF7, 1'b1});
    test_abort("abort60", 61);
    test_abort("abort_last", NS);
    test_reset_mid();
    test_clean("post_reset", 1'b0, NS + 2);
    test_run("saturate", 1, 16'hFFFF, 16'h0001, 16'h0002, 2,
             16'h0004, 3, {16'hFFFA, 1'b1});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
